fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Fetch stage of the pipeline. Holds the fetch PC and drives the instruction-memory request/response handshake.
- Supplies pc_F/pc4 to the branch predictor and consumes the predictor's pc_next, taken_F, pc_restore and flush.
- Owns the IF/ID pipeline register feeding decode (instr_D, pc_D, pc4_D, taken_D, valid_D), with stall, flush and a one-entry skid buffer.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
NOP_INSTR, 32'h0000_0013, value of instr_D when the slot holds a bubble

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
pc_next  in  32  predicted next PC from predictor (pc4 or BTB target)
taken_F  in  1  predictor taken flag for pc_F
pc_restore  in  32  redirect PC on misprediction
flush  in  1  misprediction redirect, from execute
stall_D  in  1  decode hazard stall; hold IF/ID
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address (= pc_F)
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response data valid
imem_rdata  in  32  instruction word
pc_F  out  32  current fetch PC
pc4  out  32  pc_F + 4, combinational
instr_D  out  32  instruction to decode
pc_D  out  32  PC of instr_D
pc4_D  out  32  pc_D + 4
taken_D  out  1  prediction carried with instr_D
valid_D  out  1  IF/ID slot holds a real instruction

Behaviour:
- Reset (async, rst_n=0):
  - pc_F=RESET_PC, state=REQ, buffer empty.
  - valid_D=0, instr_D=NOP_INSTR, pc_D=0, pc4_D=0, taken_D=0, in-flight registers 0.
- pc4 = pc_F+4, mod 2^32; wraps 32'hFFFF_FFFC -> 0. imem_addr = pc_F.
- At most one outstanding request. In-flight registers capture {pc_F, pc4, taken_F} on grant.
- room = ~buf_valid & ~(state==WAIT & imem_rvalid & stall_D & valid_D).
- imem_req = ~flush & room & (state==REQ | (state==WAIT & imem_rvalid)).
- FSM states REQ / WAIT / DROP:
  - REQ: if flush: pc_F<=pc_restore, stay REQ. Else if imem_req & imem_gnt: capture in-flight, pc_F<=pc_next, go WAIT.
  - WAIT, no rvalid: if flush: pc_F<=pc_restore, go DROP.
  - WAIT, rvalid & flush: discard response, pc_F<=pc_restore, go REQ.
  - WAIT, rvalid & ~flush: deliver the response. If a new request is granted the same cycle, capture in-flight, pc_F<=pc_next, stay WAIT; otherwise go REQ.
  - DROP: on rvalid, discard and go REQ. A flush in DROP updates pc_F<=pc_restore and stays DROP.
- Back-to-back zero-wait memory sustains one instruction per cycle.
- Delivery priority, evaluated each edge:
  - flush: valid_D<=0, instr_D<=NOP_INSTR, buffer cleared. flush overrides stall_D.
  - stall_D & valid_D: IF/ID held. A delivered response goes to the buffer (buf_valid<=1).
  - buf_valid: IF/ID<=buffer, buf_valid<=0. A same-cycle response cannot occur, because room blocked the request.
  - delivered response: IF/ID <= {imem_rdata, in-flight pc, pc4, taken}, valid_D<=1.
  - otherwise: valid_D<=0, instr_D<=NOP_INSTR (bubble).
- stall_D with valid_D=0 does not hold. The bubble slot is refilled.
- Latency: grant in cycle N, rvalid in N+k (k>=1), valid_D high after edge N+k.
- Responses for squashed requests never reach decode. imem_gnt/imem_rvalid outside the states above are ignored.
- No X on any output after reset.

Test Plan:
- Reset then release, zero-wait memory, pc_next=pc4, taken_F=0 -> grants at 0x0,0x4,0x8; valid_D high from the second edge, pc_D sequence 0x0,0x4,0x8, one per cycle, pc4_D=pc_D+4.
- Predicted taken: at pc_F=0x10, pc_next=0x80, taken_F=1 -> next imem_addr=0x80; the instruction at 0x10 reaches decode with taken_D=1.
- flush with pc_restore=0x200 while in WAIT, rvalid 2 cycles later -> state DROP, late response discarded, valid_D=0, next request addr=0x200.
- flush and rvalid in the same cycle -> response dropped, valid_D=0 next cycle, imem_req for pc_restore the following cycle.
- stall_D=1 for 3 cycles with valid_D=1 and a response arriving -> IF/ID unchanged, response buffered, imem_req low; on release the buffered instr loads, then fetch resumes with no loss or duplication.
- Wrap: RESET_PC=32'hFFFF_FFFC -> pc4=0, the second fetch is at 0x0. Async rst_n pulse mid-WAIT -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, the single-outstanding imem handshake and the
// IF/ID register with a one-entry skid buffer behind it.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_next,
    input  logic        taken_F,
    input  logic [31:0] pc_restore,
    input  logic        flush,
    input  logic        stall_D,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_F,
    output logic [31:0] pc4,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc4_D,
    output logic        taken_D,
    output logic        valid_D
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc_F, w_pc_F_nxt, w_pc4;
    logic [31:0] r_inf_pc, r_inf_pc4;
    logic        r_inf_taken;
    logic        r_buf_valid, r_buf_taken;
    logic [31:0] r_buf_instr, r_buf_pc, r_buf_pc4;
    logic        r_valid_D, r_taken_D;
    logic [31:0] r_instr_D, r_pc_D, r_pc4_D;
    logic        w_resp, w_room, w_req, w_grant, w_deliver;

    assign w_pc4     = r_pc_F + 32'd4;
    assign w_resp    = (r_state == S_WAIT) & imem_rvalid;
    // No new request unless a response next cycle has somewhere to land.
    assign w_room    = ~r_buf_valid & ~(w_resp & stall_D & r_valid_D);
    assign w_req     = ~flush & w_room & ((r_state == S_REQ) | w_resp);
    assign w_grant   = w_req & imem_gnt;
    assign w_deliver = w_resp & ~flush;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_F_nxt  = r_pc_F;
        case (r_state)
            S_REQ: begin
                if (flush) begin
                    w_pc_F_nxt = pc_restore;
                end else if (w_grant) begin
                    w_pc_F_nxt  = pc_next;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (flush) begin
                        w_pc_F_nxt  = pc_restore;
                        w_state_nxt = S_REQ;
                    end else if (w_grant) begin
                        w_pc_F_nxt  = pc_next;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end else if (flush) begin
                    w_pc_F_nxt  = pc_restore;
                    w_state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (flush) w_pc_F_nxt = pc_restore;
                if (imem_rvalid) w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_REQ;
            r_pc_F      <= RESET_PC;
            r_inf_pc    <= '0;
            r_inf_pc4   <= '0;
            r_inf_taken <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc_F  <= w_pc_F_nxt;
            if (w_grant) begin
                r_inf_pc    <= r_pc_F;
                r_inf_pc4   <= w_pc4;
                r_inf_taken <= taken_F;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_D   <= 1'b0;
            r_instr_D   <= NOP_INSTR;
            r_pc_D      <= '0;
            r_pc4_D     <= '0;
            r_taken_D   <= 1'b0;
            r_buf_valid <= 1'b0;
            r_buf_instr <= '0;
            r_buf_pc    <= '0;
            r_buf_pc4   <= '0;
            r_buf_taken <= 1'b0;
        end else if (flush) begin
            r_valid_D   <= 1'b0;
            r_instr_D   <= NOP_INSTR;
            r_buf_valid <= 1'b0;
        end else if (stall_D && r_valid_D) begin
            if (w_deliver) begin
                r_buf_valid <= 1'b1;
                r_buf_instr <= imem_rdata;
                r_buf_pc    <= r_inf_pc;
                r_buf_pc4   <= r_inf_pc4;
                r_buf_taken <= r_inf_taken;
            end
        end else if (r_buf_valid) begin
            r_valid_D   <= 1'b1;
            r_instr_D   <= r_buf_instr;
            r_pc_D      <= r_buf_pc;
            r_pc4_D     <= r_buf_pc4;
            r_taken_D   <= r_buf_taken;
            r_buf_valid <= 1'b0;
        end else if (w_deliver) begin
            r_valid_D <= 1'b1;
            r_instr_D <= imem_rdata;
            r_pc_D    <= r_inf_pc;
            r_pc4_D   <= r_inf_pc4;
            r_taken_D <= r_inf_taken;
        end else begin
            r_valid_D <= 1'b0;
            r_instr_D <= NOP_INSTR;
        end
    end

    assign imem_req  = w_req;
    assign imem_addr = r_pc_F;
    assign pc_F      = r_pc_F;
    assign pc4       = w_pc4;
    assign instr_D   = r_instr_D;
    assign pc_D      = r_pc_D;
    assign pc4_D     = r_pc4_D;
    assign taken_D   = r_taken_D;
    assign valid_D   = r_valid_D;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a small memory/predictor model pushes each
// response that must reach decode and pops it when decode consumes the slot.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_next = '0, pc_restore = '0, imem_rdata = '0;
    logic        taken_F = 1'b0, flush = 1'b0, stall_D = 1'b0;
    logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic        imem_req, taken_D, valid_D;
    logic [31:0] imem_addr, pc_F, pc4, instr_D, pc_D, pc4_D;

    logic        w2_req, w2_taken_D, w2_valid_D;
    logic [31:0] w2_addr, w2_pc_F, w2_pc4, w2_instr_D, w2_pc_D, w2_pc4_D;

    always #5 clk = ~clk;

    fetch_unit u_dut (
        .clk(clk), .rst_n(rst_n), .pc_next(pc_next), .taken_F(taken_F),
        .pc_restore(pc_restore), .flush(flush), .stall_D(stall_D),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pc_F(pc_F), .pc4(pc4), .instr_D(instr_D), .pc_D(pc_D),
        .pc4_D(pc4_D), .taken_D(taken_D), .valid_D(valid_D)
    );

    // Second instance only exercises the PC wrap out of reset.
    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n), .pc_next(w2_pc4), .taken_F(1'b0),
        .pc_restore(32'h0), .flush(1'b0), .stall_D(1'b0),
        .imem_req(w2_req), .imem_addr(w2_addr), .imem_gnt(1'b1),
        .imem_rvalid(1'b0), .imem_rdata(32'h0),
        .pc_F(w2_pc_F), .pc4(w2_pc4), .instr_D(w2_instr_D), .pc_D(w2_pc_D),
        .pc4_D(w2_pc4_D), .taken_D(w2_taken_D), .valid_D(w2_valid_D)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        taken;
    } exp_t;

    exp_t        sb_q[$];
    int          tests = 0, fails = 0;
    logic [31:0] exp_pc = '0;
    logic        pend_valid = 0, pend_taken = 0, pend_squash = 0;
    logic [31:0] pend_addr = '0;
    int          pend_wait = 0;
    int          lat = 1;
    logic        gnt_en = 1, flush_v = 0, stall_v = 0, rnd_mode = 0;
    logic [31:0] restore_v = '0;
    logic        mon_req, mon_grant, mon_rvalid;
    logic [31:0] mon_addr;
    int          consumed = 0, taken_seen = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0093;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic apply_inputs();
        flush      = flush_v;
        stall_D    = stall_v;
        pc_restore = restore_v;
        imem_gnt   = gnt_en;
        if (rnd_mode) begin
            taken_F = ($urandom_range(0, 3) == 0);
            pc_next = taken_F ? ($urandom() & 32'hFFFF_FFFC) : exp_pc + 32'd4;
        end else if (exp_pc == 32'h10) begin
            taken_F = 1'b1;
            pc_next = 32'h80;
        end else begin
            taken_F = 1'b0;
            pc_next = exp_pc + 32'd4;
        end
        if (pend_valid && pend_wait == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
            if (pend_valid) pend_wait--;
        end
    endtask

    task automatic monitor();
        exp_t h;
        mon_req    = imem_req;
        mon_rvalid = imem_rvalid;
        mon_grant  = imem_req & imem_gnt;
        mon_addr   = imem_addr;
        check_eq("pc_F", pc_F, exp_pc);
        check_eq("pc4", pc4, exp_pc + 32'd4);
        check_eq("imem_addr", imem_addr, exp_pc);
        check_eq("valid_D", valid_D, (sb_q.size() != 0));
        if (valid_D && sb_q.size() > 0) begin
            h = sb_q[0];
            check_eq("instr_D", instr_D, h.instr);
            check_eq("pc_D", pc_D, h.pc);
            check_eq("pc4_D", pc4_D, h.pc + 32'd4);
            check_eq("taken_D", taken_D, h.taken);
            if (!stall_D && !flush) begin
                void'(sb_q.pop_front());
                consumed++;
                if (h.taken) taken_seen++;
            end
        end
        if (flush) begin
            check_eq("req_flush", imem_req, 0);
            sb_q.delete();
        end
        if (imem_rvalid) begin
            if (!flush && !pend_squash)
                sb_q.push_back('{pc: pend_addr, instr: mem_word(pend_addr), taken: pend_taken});
            pend_valid = 1'b0;
        end else if (flush && pend_valid) begin
            pend_squash = 1'b1;
        end
        if (mon_grant) begin
            check_eq("one_outst", pend_valid, 0);
            pend_valid  = 1'b1;
            pend_addr   = exp_pc;
            pend_taken  = taken_F;
            pend_squash = 1'b0;
            pend_wait   = rnd_mode ? int'($urandom_range(0, 2)) : lat - 1;
            exp_pc      = pc_next;
        end
        if (flush) exp_pc = pc_restore;
    endtask

    task automatic step();
        apply_inputs();
        #2;
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant();
        mon_grant = 1'b0;
        for (int i = 0; i < 20 && !mon_grant; i++) step();
        check_eq("grant_wait", mon_grant, 1);
    endtask

    task automatic drain();
        gnt_en = 0; flush_v = 0; stall_v = 0;
        repeat (6) step();
        check_eq("drain_vd", valid_D, 0);
        gnt_en = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        apply_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid_D", valid_D, 0);
        check_eq("rst_instr_D", instr_D, NOP);
        check_eq("rst_pc_D", pc_D, 0);
        check_eq("rst_pc4_D", pc4_D, 0);
        check_eq("rst_taken_D", taken_D, 0);
        check_eq("rst_pc_F", pc_F, 0);
        check_eq("rst_req", imem_req, 1);
        check_eq("wrap_rst_pc", w2_pc_F, 32'hFFFF_FFFC);
        check_eq("wrap_rst_pc4", w2_pc4, 0);
        check_eq("wrap_rst_addr", w2_addr, 32'hFFFF_FFFC);
        check_eq("wrap_rst_req", w2_req, 1);
        check_eq("wrap_rst_slot", {w2_valid_D, w2_taken_D, w2_pc_D[0], w2_pc4_D[0]}, 0);
        check_eq("wrap_rst_instr", w2_instr_D, NOP);
        rst_n = 1'b1;

        // zero-wait streaming, with a predicted-taken redirect at 0x10
        step();
        check_eq("lat_edge1_vd", valid_D, 0);
        check_eq("wrap_2nd_fetch", w2_addr, 0);
        step();
        check_eq("lat_edge2_vd", valid_D, 1);
        check_eq("lat_edge2_pc", pc_D, 0);
        consumed = 0;
        repeat (10) step();
        check_eq("throughput", consumed, 10);
        check_eq("taken_seen", taken_seen, 1);

        // stall with a response landing in the skid buffer
        check_eq("pre_stall_vd", valid_D, 1);
        stall_v = 1;
        repeat (3) begin
            step();
            check_eq("stall_req", mon_req, 0);
        end
        stall_v = 0;
        step();
        check_eq("skid_req", mon_req, 0);
        step();
        check_eq("resume_req", mon_req, 1);
        repeat (5) step();
        drain();

        // flush while waiting; late response must be dropped
        lat = 3;
        wait_grant();
        flush_v = 1; restore_v = 32'h200;
        step();
        flush_v = 0;
        step();
        check_eq("drop_req", mon_req, 0);
        step();
        check_eq("drop_rvalid", mon_rvalid, 1);
        check_eq("drop_rsp_req", mon_req, 0);
        check_eq("drop_vd", valid_D, 0);
        step();
        check_eq("redir_grant", mon_grant, 1);
        check_eq("redir_addr", mon_addr, 32'h200);

        // flush coinciding with the response
        lat = 2;
        wait_grant();
        step();
        flush_v = 1; restore_v = 32'h300;
        step();
        check_eq("fr_rvalid", mon_rvalid, 1);
        flush_v = 0;
        check_eq("fr_vd", valid_D, 0);
        step();
        check_eq("fr_req", mon_req, 1);
        check_eq("fr_addr", mon_addr, 32'h300);
        drain();

        // randomised mix of latency, grant gaps, stalls and flushes
        rnd_mode = 1;
        for (int i = 0; i < 300; i++) begin
            stall_v   = ($urandom_range(0, 3) == 0);
            flush_v   = ($urandom_range(0, 15) == 0);
            gnt_en    = ($urandom_range(0, 3) != 0);
            restore_v = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            step();
        end
        rnd_mode = 0;
        drain();

        // async reset pulse in the middle of a WAIT
        lat = 1;
        restore_v = '0;
        repeat (4) step();
        check_eq("pre_rst_vd", valid_D, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid_D", valid_D, 0);
        check_eq("arst_instr_D", instr_D, NOP);
        check_eq("arst_pc_D", pc_D, 0);
        check_eq("arst_pc4_D", pc4_D, 0);
        check_eq("arst_taken_D", taken_D, 0);
        check_eq("arst_pc_F", pc_F, 0);
        check_eq("arst_pc4", pc4, 4);
        sb_q.delete();
        pend_valid = 0; pend_squash = 0; exp_pc = '0;
        imem_rvalid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) step();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
